// File: rtl/gamecube_rx_frame_controller.sv
// Frame assembler for the GameCube controller response: arms the bit receiver,
// shifts decoded bits MSB-first, checks the stop bit and flags the result.
// Optional inter-bit timeout is built only when GC_RX_TIMEOUT_EN is defined.
module gamecube_rx_frame_controller #(
  parameter int unsigned FRAME_BITS     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 400
) (
  input  logic                  CLK,
  input  logic                  n_RST,
  input  logic                  START,
  input  logic                  BIT_RX,
  input  logic                  BIT_VALID,
  input  logic                  FRAME_ACK,
  output logic                  RCV_n_RST,
  output logic [FRAME_BITS-1:0] FRAME,
  output logic                  FRAME_VALID,
  output logic                  FRAME_ERR,
  output logic                  BUSY,
  output logic [2:0]            STATE_DBG
);

  // Handshakes: BIT_VALID is a one-cycle strobe per bit (no back-pressure);
  // FRAME_VALID/FRAME_ERR stay high until FRAME_ACK is sampled in DONE/ERROR.

  localparam int unsigned BW = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_RECEIVE = 3'd2,
    S_STOP    = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_err_q, frame_err_d;

`ifdef GC_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timeout_q, timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    bit_cnt_d     = bit_cnt_q;
    frame_valid_d = frame_valid_q;
    frame_err_d   = frame_err_q;
`ifdef GC_RX_TIMEOUT_EN
    timeout_d     = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_ARM;
      end
      S_ARM: begin
        frame_d   = '0;
        bit_cnt_d = '0;
`ifdef GC_RX_TIMEOUT_EN
        timeout_d = '0;
`endif
        state_d   = S_RECEIVE;
      end
      S_RECEIVE: begin
        if (BIT_VALID) begin
          frame_d    = frame_q << 1;
          frame_d[0] = BIT_RX;
          bit_cnt_d  = bit_cnt_q + BW'(1);
`ifdef GC_RX_TIMEOUT_EN
          timeout_d  = '0;
`endif
          // Last data bit: leave on the same edge that shifts it in.
          if (bit_cnt_q == BW'(FRAME_BITS - 1)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (BIT_VALID) begin
          if (BIT_RX) begin
            state_d       = S_DONE;
            frame_valid_d = 1'b1;
          end else begin
            state_d     = S_ERROR;
            frame_err_d = 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (FRAME_ACK) begin
          frame_valid_d = 1'b0;
          frame_err_d   = 1'b0;
          state_d       = START ? S_ARM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef GC_RX_TIMEOUT_EN
    // A strobe on the limit cycle wins: the counter only advances on idle cycles.
    if ((state_q == S_RECEIVE || state_q == S_STOP) && !BIT_VALID) begin
      if (timeout_q >= TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_d   = TW'(TIMEOUT_CYCLES);
        state_d     = S_ERROR;
        frame_err_d = 1'b1;
      end else begin
        timeout_d = timeout_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge n_RST) begin
    if (!n_RST) begin
      state_q       <= S_IDLE;
      frame_q       <= '0;
      bit_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

`ifdef GC_RX_TIMEOUT_EN
  always_ff @(posedge CLK or negedge n_RST) begin
    if (!n_RST) timeout_q <= '0;
    else        timeout_q <= timeout_d;
  end
`endif

  assign RCV_n_RST   = (state_q == S_RECEIVE) || (state_q == S_STOP);
  assign FRAME       = frame_q;
  assign FRAME_VALID = frame_valid_q;
  assign FRAME_ERR   = frame_err_q;
  assign BUSY        = (state_q != S_IDLE);
  assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_gamecube_rx_frame_controller.sv
// Directed plus randomized bench for gamecube_rx_frame_controller: an 8-bit
// instance (TIMEOUT_CYCLES=20) and a 64-bit instance share clock and reset.
module tb_gamecube_rx_frame_controller;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_RECEIVE = 3'd2,
                         ST_STOP = 3'd3, ST_DONE = 3'd4, ST_ERROR = 3'd5;

  // clock / reset
  logic CLK = 1'b0;
  logic n_RST = 1'b1;
  always #5 CLK = ~CLK;

  logic       a_start = 0, a_rx = 0, a_valid = 0, a_ack = 0;
  logic       a_rcv, a_fv, a_fe, a_busy;
  logic [7:0] a_frame;
  logic [2:0] a_st;

  logic        b_start = 0, b_rx = 0, b_valid = 0, b_ack = 0;
  logic        b_rcv, b_fv, b_fe, b_busy;
  logic [63:0] b_frame;
  logic [2:0]  b_st;

  gamecube_rx_frame_controller #(.FRAME_BITS(8), .TIMEOUT_CYCLES(20)) dut_a (
    .CLK(CLK), .n_RST(n_RST), .START(a_start), .BIT_RX(a_rx), .BIT_VALID(a_valid),
    .FRAME_ACK(a_ack), .RCV_n_RST(a_rcv), .FRAME(a_frame), .FRAME_VALID(a_fv),
    .FRAME_ERR(a_fe), .BUSY(a_busy), .STATE_DBG(a_st)
  );

  gamecube_rx_frame_controller #(.FRAME_BITS(64), .TIMEOUT_CYCLES(400)) dut_b (
    .CLK(CLK), .n_RST(n_RST), .START(b_start), .BIT_RX(b_rx), .BIT_VALID(b_valid),
    .FRAME_ACK(b_ack), .RCV_n_RST(b_rcv), .FRAME(b_frame), .FRAME_VALID(b_fv),
    .FRAME_ERR(b_fe), .BUSY(b_busy), .STATE_DBG(b_st)
  );

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic        bitq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: frame value is the bit sequence read as a binary number
  function automatic logic [63:0] ref_frame(input int nbits);
    logic [63:0] v = 0;
    for (int i = 0; i < nbits; i++) v = v * 2 + 64'(bitq[i]);
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_bit(input logic b, input int gap);
    repeat (gap) tick();
    a_rx = b;
    a_valid = 1;
    tick();
    a_valid = 0;
    a_rx = 1'($urandom_range(0, 1));
  endtask

  task automatic b_bit(input logic b, input int gap);
    repeat (gap) tick();
    b_rx = b;
    b_valid = 1;
    tick();
    b_valid = 0;
    b_rx = 1'($urandom_range(0, 1));
  endtask

  task automatic a_arm();
    a_start = 1;
    tick();
    a_start = 0;
    tick();
  endtask

  task automatic a_bits8(input logic [7:0] v, input int maxgap);
    for (int i = 7; i >= 0; i--) a_bit(v[i], $urandom_range(0, maxgap));
  endtask

  task automatic a_ack_idle(input string tag);
    a_ack = 1;
    tick();
    a_ack = 0;
    check({tag, "_ack_fv"}, 64'(a_fv), 0);
    check({tag, "_ack_busy"}, 64'(a_busy), 0);
  endtask

  initial begin
    logic armed;
    logic stop_b;
    logic [63:0] e;

    // reset state
    #2 n_RST = 0;
    #2;
    check("rst_a_state", 64'(a_st), 64'(ST_IDLE));
    check("rst_a_frame", 64'(a_frame), 0);
    check("rst_a_flags", {a_fv, a_fe, a_busy, a_rcv}, 0);
    check("rst_b_flags", {b_fv, b_fe, b_busy, b_rcv}, 0);
    @(negedge CLK) n_RST = 1;
    tick();
    check("idle_wait", 64'(a_st), 64'(ST_IDLE));

    // good frame 0xB2
    a_start = 1;
    tick();
    a_start = 0;
    check("arm_state", 64'(a_st), 64'(ST_ARM));
    check("arm_rcv", 64'(a_rcv), 0);
    check("arm_busy", 64'(a_busy), 1);
    tick();
    check("recv_state", 64'(a_st), 64'(ST_RECEIVE));
    check("recv_rcv", 64'(a_rcv), 1);
    a_bits8(8'hB2, 3);
    check("stop_state", 64'(a_st), 64'(ST_STOP));
    check("stop_fv_low", 64'(a_fv), 0);
    a_bit(1'b1, 2);
    check("b2_fv", 64'(a_fv), 1);
    check("b2_fe", 64'(a_fe), 0);
    check("b2_frame", 64'(a_frame), 64'hB2);
    a_valid = 1; a_rx = 0; a_start = 1;
    repeat (2) tick();
    a_valid = 0; a_start = 0;
    check("b2_hold_fv", 64'(a_fv), 1);
    check("b2_hold_frame", 64'(a_frame), 64'hB2);
    check("b2_hold_state", 64'(a_st), 64'(ST_DONE));
    a_ack_idle("b2");

    // bad stop bit
    a_arm();
    a_bits8(8'h5C, 2);
    a_bit(1'b0, 1);
    check("bad_stop_fe", 64'(a_fe), 1);
    check("bad_stop_fv", 64'(a_fv), 0);
    check("bad_stop_frame", 64'(a_frame), 64'h5C);
    a_ack_idle("bad_stop");

    // ACK and START together in DONE
    a_arm();
    a_bits8(8'h3A, 1);
    a_bit(1'b1, 0);
    check("rearm_pre_fv", 64'(a_fv), 1);
    a_ack = 1; a_start = 1;
    tick();
    a_ack = 0; a_start = 0;
    check("rearm_fv", 64'(a_fv), 0);
    check("rearm_state", 64'(a_st), 64'(ST_ARM));
    check("rearm_rcv", 64'(a_rcv), 0);
    tick();
    check("rearm_recv", 64'(a_st), 64'(ST_RECEIVE));
    check("rearm_frame_clr", 64'(a_frame), 0);
    // strobes landing exactly on the 20th cycle are accepted (also from arm)
    for (int i = 7; i >= 0; i--) a_bit(1'((8'hC5 >> i) & 1), 19);
    a_bit(1'b1, 19);
    check("edge_fv", 64'(a_fv), 1);
    check("edge_fe", 64'(a_fe), 0);
    check("edge_frame", 64'(a_frame), 64'hC5);
    a_ack_idle("edge");

    // silence after 3 bits
    a_arm();
    a_bit(1'b1, 0);
    a_bit(1'b1, 1);
    a_bit(1'b0, 0);
    repeat (19) tick();
    check("silence19_fe", 64'(a_fe), 0);
    check("silence19_busy", 64'(a_busy), 1);
`ifdef GC_RX_TIMEOUT_EN
    tick();
    check("timeout_fe", 64'(a_fe), 1);
    check("timeout_fv", 64'(a_fv), 0);
    check("timeout_state", 64'(a_st), 64'(ST_ERROR));
    check("timeout_frame", 64'(a_frame), 64'h06);
    a_ack_idle("timeout");
`else
    repeat (981) tick();
    check("nowait_busy", 64'(a_busy), 1);
    check("nowait_fe", 64'(a_fe), 0);
    check("nowait_state", 64'(a_st), 64'(ST_RECEIVE));
    for (int i = 4; i >= 0; i--) a_bit(1'((5'b10011 >> i) & 1), 0);
    a_bit(1'b1, 0);
    check("nowait_frame", 64'(a_frame), 64'hD3);
    check("nowait_fv", 64'(a_fv), 1);
    a_ack_idle("nowait");
`endif

    // randomized frames against the reference model
    armed = 0;
    for (int k = 0; k < 16; k++) begin
      bitq.delete();
      for (int i = 0; i < 8; i++) bitq.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(ref_frame(8));
      stop_b = ($urandom_range(0, 3) != 0);
      if (!armed) begin
        a_start = 1;
        tick();
        a_start = 0;
      end
      tick();
      for (int i = 0; i < 8; i++) a_bit(bitq[i], $urandom_range(0, 6));
      a_bit(stop_b, $urandom_range(0, 6));
      e = exp_q.pop_front();
      check("rand_frame", 64'(a_frame), e);
      check("rand_fv", 64'(a_fv), 64'(stop_b));
      check("rand_fe", 64'(a_fe), 64'(!stop_b));
      armed = 1'($urandom_range(0, 1));
      a_ack = 1; a_start = armed;
      tick();
      a_ack = 0; a_start = 0;
      check("rand_ack_flags", {a_fv, a_fe}, 0);
    end

    // reset mid-frame on the 64-bit instance, then a full frame
    b_start = 1;
    tick();
    b_start = 0;
    tick();
    for (int i = 0; i < 5; i++) b_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
    check("b_mid_busy", 64'(b_busy), 1);
    n_RST = 0;
    #2;
    check("b_rst_state", 64'(b_st), 64'(ST_IDLE));
    check("b_rst_frame", b_frame, 0);
    check("b_rst_flags", {b_fv, b_fe, b_busy, b_rcv}, 0);
    @(negedge CLK) n_RST = 1;
    tick();
    check("b_post_rst_idle", 64'(b_st), 64'(ST_IDLE));
    bitq.delete();
    for (int i = 0; i < 64; i++) bitq.push_back(1'($urandom_range(0, 1)));
    exp_q.push_back(ref_frame(64));
    b_start = 1;
    tick();
    b_start = 0;
    tick();
    for (int i = 0; i < 64; i++) b_bit(bitq[i], $urandom_range(0, 2));
    check("b64_stop_state", 64'(b_st), 64'(ST_STOP));
    b_bit(1'b1, 1);
    e = exp_q.pop_front();
    check("b64_frame", b_frame, e);
    check("b64_fv", 64'(b_fv), 1);
    b_ack = 1;
    tick();
    b_ack = 0;
    check("b64_ack_busy", {b_busy, b_fv}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gamecube_rx_frame_controller.md
GAMECUBE_RX_FRAME_CONTROLLER -- requirements
Module: gamecube_rx_frame_controller

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 64, giving the number of data bits per response frame, excluding the stop bit.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 400, giving the maximum CLK cycles allowed between decoded bits, and from arm to the first bit.
REQ-003 The block SHALL have port CLK, input, width 1: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port n_RST, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port START, input, width 1: a request to arm reception of one frame.
REQ-006 The block SHALL have port BIT_RX, input, width 1: the decoded bit value from the bit receiver.
REQ-007 The block SHALL have port BIT_VALID, input, width 1: a one-cycle strobe from the bit receiver; each high cycle is one bit.
REQ-008 The block SHALL have port FRAME_ACK, input, width 1: the consumer acknowledges the frame or error.
REQ-009 The block SHALL have port RCV_n_RST, output, width 1: drives the bit receiver reset (active-low).
REQ-010 The block SHALL have port FRAME, output, width FRAME_BITS: the assembled frame, first-received bit in the MSB.
REQ-011 The block SHALL have port FRAME_VALID, output, width 1: FRAME holds a good frame.
REQ-012 The block SHALL have port FRAME_ERR, output, width 1: the reception failed (bad stop bit or timeout).
REQ-013 The block SHALL have port BUSY, output, width 1: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, ARM, RECEIVE, STOP, DONE and ERROR.
REQ-015 In IDLE, START=1 SHALL move the FSM to ARM on the next edge; otherwise the FSM SHALL remain in IDLE.
REQ-016 ARM SHALL last exactly one cycle with RCV_n_RST=0, clear the bit counter, the timeout counter and FRAME, then move to RECEIVE.
REQ-017 RCV_n_RST SHALL be 0 in IDLE, ARM, DONE and ERROR, and 1 in RECEIVE and STOP.
REQ-018 In RECEIVE, each cycle with BIT_VALID=1 SHALL shift FRAME left by one with BIT_RX into the LSB, increment the bit counter and clear the timeout counter.
REQ-019 When the bit counter reaches FRAME_BITS, the FSM SHALL move to STOP on the same edge as the last data-bit shift.
REQ-020 In STOP, BIT_VALID=1 with BIT_RX=1 SHALL move the FSM to DONE, and BIT_VALID=1 with BIT_RX=0 SHALL move it to ERROR; FRAME SHALL not shift in STOP.
REQ-021 FRAME_VALID SHALL rise on the edge after the stop-bit strobe is sampled, giving a latency of 1 cycle.
REQ-022 FRAME_VALID and FRAME_ERR SHALL be registered outputs, mutually exclusive, and held until FRAME_ACK=1 is sampled.
REQ-023 FRAME SHALL be stable while the FSM is in DONE or ERROR.
REQ-024 In DONE or ERROR, FRAME_ACK=1 SHALL clear the flag and return the FSM to IDLE.
REQ-025 In DONE or ERROR, FRAME_ACK=1 together with START=1 SHALL clear the flag and go directly to ARM.
REQ-026 START SHALL be ignored in all states other than IDLE, DONE and ERROR.
REQ-027 FRAME_ACK SHALL be ignored outside DONE and ERROR.
REQ-028 BIT_VALID SHALL be ignored in IDLE, ARM, DONE and ERROR.
REQ-029 The bit counter SHALL be $clog2(FRAME_BITS+1) bits wide and SHALL never wrap.
REQ-030 The timeout counter SHALL saturate at TIMEOUT_CYCLES and SHALL never wrap.
REQ-031 If BIT_VALID=1 coincides with the timeout counter reaching its limit, the bit SHALL be accepted and the timeout SHALL not fire.

Reset
REQ-032 n_RST=0 SHALL asynchronously force IDLE, with FRAME=0, FRAME_VALID=0, FRAME_ERR=0, BUSY=0 and RCV_n_RST=0, and zero both counters.
REQ-033 A reset asserted mid-frame SHALL discard the partial frame with no flag raised.
REQ-034 After n_RST deasserts, the block SHALL wait in IDLE for START.

Configuration
REQ-035 With macro GC_RX_TIMEOUT_EN defined, the timeout counter SHALL be built, and reaching TIMEOUT_CYCLES in RECEIVE or STOP SHALL move the FSM to ERROR with FRAME_ERR=1.
REQ-036 Without GC_RX_TIMEOUT_EN, no timeout logic SHALL exist, RECEIVE and STOP SHALL wait indefinitely, and TIMEOUT_CYCLES SHALL be unused; all other behaviour SHALL be identical.

Verification
REQ-037 The bench SHALL cover: FRAME_BITS=8, START, bits 1,0,1,1,0,0,1,0 then stop 1 -> FRAME=8'hB2, FRAME_VALID=1 one cycle after the stop strobe, held until ACK, then IDLE and BUSY=0.
REQ-038 The bench SHALL cover: FRAME_BITS=8, eight bits then stop bit 0 -> FRAME_ERR=1, FRAME_VALID=0, FRAME holds the 8 bits.
REQ-039 The bench SHALL cover: GC_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, 3 bits then silence -> FRAME_ERR=1 exactly 20 cycles after the last strobe; without the macro -> still BUSY after 1000 cycles.
REQ-040 The bench SHALL cover: the bit strobe on the same cycle the timeout counter reaches 20 -> bit accepted, no error.
REQ-041 The bench SHALL cover: n_RST pulsed low after 5 of 64 bits -> immediate IDLE, all outputs at reset values; a following START plus a full 64-bit frame -> correct FRAME.
REQ-042 The bench SHALL cover: FRAME_ACK and START together in DONE -> FRAME_VALID=0 next cycle, ARM for one cycle with RCV_n_RST=0, then RECEIVE.
